e203_exu_alu_rglr_pipe: RTL and testbench
=========================================

Name: e203_exu_alu_rglr_pipe

Overview:
Parametrised successor to the regular-ALU issue/commit unit in the EXU.
- Selects operands and decodes request strobes to the shared ALU datapath, as before.
- Adds a DEPTH-entry result buffer between the shared ALU result and the write-back/commit interface, so commit back-pressure no longer stalls issue while entries are free.
- Adds flush support and occupancy reporting.

Parameters:
- XLEN, 32, data width of operands and result.
- PC_SIZE, 32, width of alu_i_pc; zero-extended to XLEN when selected as op1.
- DEPTH, 2, result buffer entries; legal range 1..8, need not be a power of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_i_valid  in  1  issue valid
- alu_i_ready  out  1  issue ready
- alu_i_rs1, alu_i_rs2, alu_i_imm  in  XLEN each  operands
- alu_i_pc  in  PC_SIZE  instruction PC
- alu_i_info  in  E203_DECINFO_ALU_WIDTH  decoded ALU info bus
- alu_i_flush  in  1  discard all buffered results
- alu_o_valid  out  1  commit valid
- alu_o_ready  in  1  commit ready
- alu_o_wbck_wdat  out  XLEN  result
- alu_o_wbck_err  out  1  ecall | ebreak | wfi
- alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi  out  1 each  commit flags
- alu_o_cnt  out  CNT_W  buffer occupancy
- alu_req_alu_{add,sub,xor,sll,srl,sra,or,and,slt,sltu,lui}  out  1 each  ALU op strobes
- alu_req_alu_op1, alu_req_alu_op2  out  XLEN each  ALU operands
- alu_req_alu_res  in  XLEN  shared ALU result, combinational from the req outputs

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-low reset rst_n clears count, wptr and rptr to 0. Storage is not reset.

Combinational request path:
- op1 = OP1PC ? pc : rs1.
- op2 = OP2IMM ? imm : rs2.
- Each strobe = its info bit & alu_i_valid.
- add is additionally masked by ~NOP.

Buffer entry:
- Fields: {wdat = alu_req_alu_res, ecall, ebreak, wfi}.
- err is derived from the flags at the output.

Handshake:
- alu_i_ready = (count != DEPTH). It never depends on alu_o_ready.
- push = alu_i_valid & alu_i_ready & ~flush & ~bypass.
- pop = alu_o_valid & alu_o_ready & ~bypass.
- count changes by +1 on push, -1 on pop, 0 on both or neither.
- Full and pop in the same cycle: no push that cycle; ready rises the next cycle.
- wptr and rptr wrap from DEPTH-1 to 0 explicitly.

Output:
- alu_o_valid = (count != 0).
- Data and flags come from entry[rptr].
- All alu_o_* data and flag outputs are forced to 0 while alu_o_valid = 0.
- Reset values: alu_o_valid = 0, all data/flag outputs 0, alu_o_cnt = 0, alu_i_ready = 1.

Latency: issue to alu_o_valid is 1 cycle (without bypass).

Flush:
- Next edge: count = 0, wptr = rptr = 0.
- An issue handshake in the flush cycle is dropped.
- alu_o_valid may be high in the flush cycle; a pop in that cycle still counts as committed.

Reset mid-operation: all entries are lost and outputs return to their reset values immediately (asynchronous).

Optional Feature:
Macro E203_ALU_RGLR_BYPASS_EN.
- Defined:
  - bypass = (count == 0) & alu_i_valid & alu_o_ready & ~flush.
  - alu_o_valid = (count != 0) | (alu_i_valid & ~flush).
  - When count = 0, the output mux selects the live ALU result and flags. This gives 0-cycle latency, with no write and no pointer move.
  - If count = 0 and alu_o_ready = 0, the issued instruction is pushed normally.
- Undefined: bypass is tied to 0 and latency is always 1.

Decomposition:
- Shared package/defines:
  - E203_DECINFO_ALU_* bit indices and E203_DECINFO_ALU_WIDTH (existing).
  - A new entry-width constant E203_ALU_RGLR_ENT_W = XLEN+3.
- One natural sub-module: e203_exu_alu_rglr_fifo (DEPTH x ENT_W storage, pointers, count, flush).
- Decode and output muxing stay in the top level.

Test Plan:
- Reset, no bypass: reset -> alu_o_valid = 0, alu_o_cnt = 0, alu_i_ready = 1.
  - Issue ADD rs1 = 5, rs2 = 7 -> alu_req_alu_add = 1; next cycle wdat = 12, cnt = 1.
- Fill with DEPTH = 2, alu_o_ready = 0: issue 3 ADDIs (imm 1, 2, 3; rs1 = 0).
  - Third is stalled, alu_i_ready = 0, cnt = 2.
  - Raise ready -> outputs 1, then 2, then 3 in order.
  - Wrap: rptr passes 1 -> 0.
- Full with simultaneous pop: count = 2, alu_o_ready = 1, alu_i_valid = 1 -> no push that cycle; cnt = 1; ready = 1 the next cycle.
- ECALL info: wdat = 0 from the masked strobe, alu_o_cmt_ecall = 1, alu_o_wbck_err = 1. A following NOP (ADDI x0) gives alu_req_alu_add = 0.
- Flush: cnt = 2 with issue asserted in the same cycle as alu_i_flush -> next cycle cnt = 0, alu_o_valid = 0, and the issued entry never appears.
- Bypass (macro defined): count = 0, alu_o_ready = 1, SUB rs1 = 9, rs2 = 4 -> alu_o_valid = 1 and wdat = 5 in the same cycle; cnt stays 0.

Source files
------------

// File: rtl/e203_exu_alu_rglr_pipe_pkg.sv
// Regular-ALU issue/commit pipe: shared decode-info layout
// and buffer entry width.
package e203_exu_alu_rglr_pipe_pkg;

  localparam int E203_XLEN = 32;

  localparam int E203_DECINFO_ALU_ADD    = 0;
  localparam int E203_DECINFO_ALU_SUB    = 1;
  localparam int E203_DECINFO_ALU_XOR    = 2;
  localparam int E203_DECINFO_ALU_SLL    = 3;
  localparam int E203_DECINFO_ALU_SRL    = 4;
  localparam int E203_DECINFO_ALU_SRA    = 5;
  localparam int E203_DECINFO_ALU_OR     = 6;
  localparam int E203_DECINFO_ALU_AND    = 7;
  localparam int E203_DECINFO_ALU_SLT    = 8;
  localparam int E203_DECINFO_ALU_SLTU   = 9;
  localparam int E203_DECINFO_ALU_LUI    = 10;
  localparam int E203_DECINFO_ALU_OP2IMM = 11;
  localparam int E203_DECINFO_ALU_OP1PC  = 12;
  localparam int E203_DECINFO_ALU_NOP    = 13;
  localparam int E203_DECINFO_ALU_ECAL   = 14;
  localparam int E203_DECINFO_ALU_EBRK   = 15;
  localparam int E203_DECINFO_ALU_WFI    = 16;
  localparam int E203_DECINFO_ALU_WIDTH  = 17;

  // Entry = {wdat, ecall, ebreak, wfi}
  localparam int E203_ALU_RGLR_ENT_W = E203_XLEN + 3;

  function automatic int alu_rglr_ent_w(input int xlen);
    return xlen + 3;
  endfunction

endpackage

// File: rtl/e203_exu_alu_rglr_fifo.sv
// Result buffer: DEPTH x W storage with explicit-wrap
// pointers, occupancy count and synchronous flush.
module e203_exu_alu_rglr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 35,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     wdat_i,
  output logic [W-1:0]     rdat_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next pointers and count; flush overrides everything
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop_i) begin
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/e203_exu_alu_rglr_pipe.sv
// Regular-ALU issue/commit with result buffer and flush.
// Optional same-cycle bypass: E203_ALU_RGLR_BYPASS_EN.
module e203_exu_alu_rglr_pipe
  import e203_exu_alu_rglr_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_i_valid,
  output logic                   alu_i_ready,
  input  logic [XLEN-1:0]        alu_i_rs1,
  input  logic [XLEN-1:0]        alu_i_rs2,
  input  logic [XLEN-1:0]        alu_i_imm,
  input  logic [PC_SIZE-1:0]     alu_i_pc,
  input  logic [E203_DECINFO_ALU_WIDTH-1:0] alu_i_info,
  input  logic                   alu_i_flush,
  output logic                   alu_o_valid,
  input  logic                   alu_o_ready,
  output logic [XLEN-1:0]        alu_o_wbck_wdat,
  output logic                   alu_o_wbck_err,
  output logic                   alu_o_cmt_ecall,
  output logic                   alu_o_cmt_ebreak,
  output logic                   alu_o_cmt_wfi,
  output logic [CNT_W-1:0]       alu_o_cnt,
  output logic                   alu_req_alu_add,
  output logic                   alu_req_alu_sub,
  output logic                   alu_req_alu_xor,
  output logic                   alu_req_alu_sll,
  output logic                   alu_req_alu_srl,
  output logic                   alu_req_alu_sra,
  output logic                   alu_req_alu_or,
  output logic                   alu_req_alu_and,
  output logic                   alu_req_alu_slt,
  output logic                   alu_req_alu_sltu,
  output logic                   alu_req_alu_lui,
  output logic [XLEN-1:0]        alu_req_alu_op1,
  output logic [XLEN-1:0]        alu_req_alu_op2,
  input  logic [XLEN-1:0]        alu_req_alu_res
);

  localparam int ENT_W = alu_rglr_ent_w(XLEN);

  logic [XLEN-1:0]  pc_ext;
  logic [ENT_W-1:0] live_ent;
  logic [ENT_W-1:0] buf_ent;
  logic [ENT_W-1:0] sel_ent;
  logic [ENT_W-1:0] out_ent;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             bypass;
  logic             push;
  logic             pop;

  assign pc_ext = XLEN'(alu_i_pc);

  assign alu_req_alu_op1 =
    alu_i_info[E203_DECINFO_ALU_OP1PC] ? pc_ext : alu_i_rs1;
  assign alu_req_alu_op2 =
    alu_i_info[E203_DECINFO_ALU_OP2IMM] ? alu_i_imm : alu_i_rs2;

  assign alu_req_alu_add = alu_i_valid
    & alu_i_info[E203_DECINFO_ALU_ADD]
    & ~alu_i_info[E203_DECINFO_ALU_NOP];
  assign alu_req_alu_sub  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_SUB];
  assign alu_req_alu_xor  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_XOR];
  assign alu_req_alu_sll  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_SLL];
  assign alu_req_alu_srl  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_SRL];
  assign alu_req_alu_sra  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_SRA];
  assign alu_req_alu_or   = alu_i_valid & alu_i_info[E203_DECINFO_ALU_OR];
  assign alu_req_alu_and  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_AND];
  assign alu_req_alu_slt  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_SLT];
  assign alu_req_alu_sltu = alu_i_valid & alu_i_info[E203_DECINFO_ALU_SLTU];
  assign alu_req_alu_lui  = alu_i_valid & alu_i_info[E203_DECINFO_ALU_LUI];

  assign live_ent = {
    alu_req_alu_res,
    alu_i_info[E203_DECINFO_ALU_ECAL],
    alu_i_info[E203_DECINFO_ALU_EBRK],
    alu_i_info[E203_DECINFO_ALU_WFI]
  };

  assign cnt_zero    = (cnt == '0);
  assign alu_i_ready = (cnt != CNT_W'(DEPTH));

`ifdef E203_ALU_RGLR_BYPASS_EN
  assign bypass = cnt_zero & alu_i_valid
                & alu_o_ready & ~alu_i_flush;
  assign alu_o_valid = ~cnt_zero | (alu_i_valid & ~alu_i_flush);
  assign sel_ent = cnt_zero ? live_ent : buf_ent;
`else
  assign bypass      = 1'b0;
  assign alu_o_valid = ~cnt_zero;
  assign sel_ent     = buf_ent;
`endif

  assign push = alu_i_valid & alu_i_ready & ~alu_i_flush & ~bypass;
  assign pop  = alu_o_valid & alu_o_ready & ~bypass;

  e203_exu_alu_rglr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (alu_i_flush),
    .wdat_i  (live_ent),
    .rdat_o  (buf_ent),
    .cnt_o   (cnt)
  );

  assign out_ent = alu_o_valid ? sel_ent : '0;

  assign alu_o_wbck_wdat  = out_ent[ENT_W-1:3];
  assign alu_o_cmt_ecall  = out_ent[2];
  assign alu_o_cmt_ebreak = out_ent[1];
  assign alu_o_cmt_wfi    = out_ent[0];
  assign alu_o_wbck_err   = |out_ent[2:0];
  assign alu_o_cnt        = cnt;

endmodule

// File: tb/tb_e203_exu_alu_rglr_pipe.sv
// Bench for e203_exu_alu_rglr_pipe: task per scenario,
// queue scoreboard compared at every commit handshake.
module tb_e203_exu_alu_rglr_pipe;
  import e203_exu_alu_rglr_pipe_pkg::*;

  localparam int XL = 32;
  localparam int DP = 2;
  localparam int CW = $clog2(DP + 1);
  localparam int K_ADD = 0, K_SUB = 1, K_XOR = 2, K_ADDI = 3;
  localparam int K_ECALL = 4, K_NOP = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic alu_i_valid, alu_i_ready, alu_i_flush;
  logic [XL-1:0] alu_i_rs1, alu_i_rs2, alu_i_imm, alu_i_pc;
  logic [E203_DECINFO_ALU_WIDTH-1:0] alu_i_info;
  logic alu_o_valid, alu_o_ready;
  logic [XL-1:0] alu_o_wbck_wdat;
  logic alu_o_wbck_err, alu_o_cmt_ecall;
  logic alu_o_cmt_ebreak, alu_o_cmt_wfi;
  logic [CW-1:0] alu_o_cnt;
  logic r_add, r_sub, r_xor, r_sll, r_srl, r_sra;
  logic r_or, r_and, r_slt, r_sltu, r_lui;
  logic [XL-1:0] op1, op2, res;

  logic [XL+2:0] exp_ent;
  logic [XL+2:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  e203_exu_alu_rglr_pipe #(
    .XLEN(XL), .PC_SIZE(XL), .DEPTH(DP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready),
    .alu_i_rs1(alu_i_rs1), .alu_i_rs2(alu_i_rs2),
    .alu_i_imm(alu_i_imm), .alu_i_pc(alu_i_pc),
    .alu_i_info(alu_i_info), .alu_i_flush(alu_i_flush),
    .alu_o_valid(alu_o_valid), .alu_o_ready(alu_o_ready),
    .alu_o_wbck_wdat(alu_o_wbck_wdat),
    .alu_o_wbck_err(alu_o_wbck_err),
    .alu_o_cmt_ecall(alu_o_cmt_ecall),
    .alu_o_cmt_ebreak(alu_o_cmt_ebreak),
    .alu_o_cmt_wfi(alu_o_cmt_wfi),
    .alu_o_cnt(alu_o_cnt),
    .alu_req_alu_add(r_add), .alu_req_alu_sub(r_sub),
    .alu_req_alu_xor(r_xor), .alu_req_alu_sll(r_sll),
    .alu_req_alu_srl(r_srl), .alu_req_alu_sra(r_sra),
    .alu_req_alu_or(r_or), .alu_req_alu_and(r_and),
    .alu_req_alu_slt(r_slt), .alu_req_alu_sltu(r_sltu),
    .alu_req_alu_lui(r_lui),
    .alu_req_alu_op1(op1), .alu_req_alu_op2(op2),
    .alu_req_alu_res(res)
  );

  // Shared ALU datapath model (external to the DUT)
  always_comb begin
    res = '0;
    if (r_add) res = op1 + op2;
    else if (r_sub) res = op1 - op2;
    else if (r_xor) res = op1 ^ op2;
    else if (r_sll) res = op1 << op2[4:0];
    else if (r_srl) res = op1 >> op2[4:0];
    else if (r_sra) res = $signed(op1) >>> op2[4:0];
    else if (r_or) res = op1 | op2;
    else if (r_and) res = op1 & op2;
    else if (r_slt) res = {31'd0, $signed(op1) < $signed(op2)};
    else if (r_sltu) res = {31'd0, op1 < op2};
    else if (r_lui) res = op2;
  end

  // Scoreboard: push on accepted issue, compare on commit
  always @(negedge clk) begin
    logic [XL+2:0] e, got;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (alu_i_valid && alu_i_ready && !alu_i_flush)
        sb.push_back(exp_ent);
      if (alu_o_valid && alu_o_ready) begin
        n_chk++;
        got = {alu_o_wbck_wdat, alu_o_cmt_ecall,
               alu_o_cmt_ebreak, alu_o_cmt_wfi};
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL commit_unexpected got=%h", got);
        end else begin
          e = sb.pop_front();
          if (got !== e || alu_o_wbck_err !== (|e[2:0])) begin
            n_fail++;
            $display("FAIL commit got=%h err=%b exp=%h",
                     got, alu_o_wbck_err, e);
          end
        end
      end
      if (alu_i_flush) sb.delete();
    end
  end

  task automatic set_op(input int k, input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] im);
    logic [31:0] w;
    logic ec;
    alu_i_info = '0;
    alu_i_rs1 = a;
    alu_i_rs2 = b;
    alu_i_imm = im;
    alu_i_pc = 32'h8000_0000;
    alu_i_valid = 1'b1;
    ec = 1'b0;
    w = '0;
    case (k)
      K_ADD: begin
        alu_i_info[E203_DECINFO_ALU_ADD] = 1'b1;
        w = a + b;
      end
      K_SUB: begin
        alu_i_info[E203_DECINFO_ALU_SUB] = 1'b1;
        w = a - b;
      end
      K_XOR: begin
        alu_i_info[E203_DECINFO_ALU_XOR] = 1'b1;
        w = a ^ b;
      end
      K_ADDI: begin
        alu_i_info[E203_DECINFO_ALU_ADD] = 1'b1;
        alu_i_info[E203_DECINFO_ALU_OP2IMM] = 1'b1;
        w = a + im;
      end
      K_ECALL: begin
        alu_i_info[E203_DECINFO_ALU_ECAL] = 1'b1;
        ec = 1'b1;
      end
      default: begin
        alu_i_info[E203_DECINFO_ALU_ADD] = 1'b1;
        alu_i_info[E203_DECINFO_ALU_OP2IMM] = 1'b1;
        alu_i_info[E203_DECINFO_ALU_NOP] = 1'b1;
      end
    endcase
    exp_ent = {w, ec, 1'b0, 1'b0};
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && alu_o_cnt != 0; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (alu_o_cnt !== 0 || alu_o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain cnt=%0d exp=0", nm, alu_o_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_i_valid = 0; alu_i_flush = 0; alu_o_ready = 0;
    alu_i_info = '0; alu_i_rs1 = 0; alu_i_rs2 = 0;
    alu_i_imm = 0; alu_i_pc = 0; exp_ent = '0;
    #12;
    n_chk++;
    if (alu_o_valid !== 1'b0 || alu_o_cnt !== 0 ||
        alu_i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state v=%b c=%0d r=%b exp 0/0/1",
               alu_o_valid, alu_o_cnt, alu_i_ready);
    end
    n_chk++;
    if (alu_o_wbck_wdat !== 0 || alu_o_wbck_err !== 0) begin
      n_fail++;
      $display("FAIL reset_data wdat=%h err=%b exp 0",
               alu_o_wbck_wdat, alu_o_wbck_err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(posedge clk); #1;
    alu_o_ready = 0;
    set_op(K_ADD, 5, 7, 0);
    #1;
    n_chk++;
    if (r_add !== 1 || r_sub !== 0 || op1 !== 5 || op2 !== 7) begin
      n_fail++;
      $display("FAIL add_req add=%b op1=%0d op2=%0d exp 1/5/7",
               r_add, op1, op2);
    end
    n_chk++;
    if (alu_o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency valid=%b exp 0", alu_o_valid);
    end
    @(posedge clk); #1;
    alu_i_valid = 0;
    n_chk++;
    if (alu_o_valid !== 1 || alu_o_wbck_wdat !== 12 ||
        alu_o_cnt !== 1) begin
      n_fail++;
      $display("FAIL add_out v=%b wdat=%0d cnt=%0d exp 1/12/1",
               alu_o_valid, alu_o_wbck_wdat, alu_o_cnt);
    end
    alu_o_ready = 1;
    drain("add");
  endtask

  task automatic test_fill();
    alu_o_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      set_op(K_ADDI, 0, 32'hdead, i);
    end
    #1;
    n_chk++;
    if (alu_i_ready !== 0 || alu_o_cnt !== 2) begin
      n_fail++;
      $display("FAIL fill_full ready=%b cnt=%0d exp 0/2",
               alu_i_ready, alu_o_cnt);
    end
    @(posedge clk); #1;
    alu_o_ready = 1;
    #1;
    n_chk++;
    if (alu_i_ready !== 0) begin
      n_fail++;
      $display("FAIL ready_indep ready=%b exp 0", alu_i_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (alu_o_cnt !== 1 || alu_i_ready !== 1) begin
      n_fail++;
      $display("FAIL full_pop cnt=%0d ready=%b exp 1/1",
               alu_o_cnt, alu_i_ready);
    end
    @(posedge clk); #1;
    alu_i_valid = 0;
    drain("fill");
  endtask

  task automatic test_ecall();
    @(posedge clk); #1;
    alu_o_ready = 0;
    set_op(K_ECALL, 3, 4, 0);
    @(posedge clk); #1;
    set_op(K_NOP, 0, 0, 0);
    #1;
    n_chk++;
    if (r_add !== 0) begin
      n_fail++;
      $display("FAIL nop_add add=%b exp 0", r_add);
    end
    n_chk++;
    if (alu_o_wbck_wdat !== 0 || alu_o_cmt_ecall !== 1 ||
        alu_o_wbck_err !== 1 || alu_o_cmt_wfi !== 0) begin
      n_fail++;
      $display("FAIL ecall_out wdat=%h ec=%b err=%b exp 0/1/1",
               alu_o_wbck_wdat, alu_o_cmt_ecall, alu_o_wbck_err);
    end
    @(posedge clk); #1;
    alu_i_valid = 0;
    alu_o_ready = 1;
    drain("ecall");
  endtask

  task automatic test_flush();
    alu_o_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_op(K_ADDI, 10, 0, i);
    end
    @(posedge clk); #1;
    set_op(K_ADDI, 99, 0, 0);
    alu_i_flush = 1;
    @(posedge clk); #1;
    alu_i_flush = 0;
    alu_i_valid = 0;
    n_chk++;
    if (alu_o_cnt !== 0 || alu_o_valid !== 0) begin
      n_fail++;
      $display("FAIL flush_full cnt=%0d v=%b exp 0/0",
               alu_o_cnt, alu_o_valid);
    end
    set_op(K_ADDI, 20, 0, 0);
    @(posedge clk); #1;
    set_op(K_ADDI, 77, 0, 0);
    alu_i_flush = 1;
    @(posedge clk); #1;
    alu_i_flush = 0;
    n_chk++;
    if (alu_o_cnt !== 0 || alu_o_valid !== 0) begin
      n_fail++;
      $display("FAIL flush_one cnt=%0d v=%b exp 0/0",
               alu_o_cnt, alu_o_valid);
    end
    set_op(K_ADDI, 42, 0, 0);
    alu_o_ready = 1;
    @(posedge clk); #1;
    alu_i_valid = 0;
    drain("flush");
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    alu_o_ready = 1;
    set_op(K_SUB, 9, 4, 0);
    #1;
    n_chk++;
`ifdef E203_ALU_RGLR_BYPASS_EN
    if (alu_o_valid !== 1 || alu_o_wbck_wdat !== 5) begin
      n_fail++;
      $display("FAIL bypass_out v=%b wdat=%0d exp 1/5",
               alu_o_valid, alu_o_wbck_wdat);
    end
    @(posedge clk); #1;
    alu_i_valid = 0;
    n_chk++;
    if (alu_o_cnt !== 0) begin
      n_fail++;
      $display("FAIL bypass_cnt cnt=%0d exp 0", alu_o_cnt);
    end
`else
    if (alu_o_valid !== 0) begin
      n_fail++;
      $display("FAIL nobypass_out v=%b exp 0", alu_o_valid);
    end
    @(posedge clk); #1;
    alu_i_valid = 0;
    n_chk++;
    if (alu_o_valid !== 1 || alu_o_wbck_wdat !== 5) begin
      n_fail++;
      $display("FAIL sub_out v=%b wdat=%0d exp 1/5",
               alu_o_valid, alu_o_wbck_wdat);
    end
`endif
    drain("bypass");
  endtask

  task automatic test_back_to_back();
    alu_o_ready = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      set_op($urandom_range(0, 3), $urandom, $urandom, $urandom);
      #1;
      n_chk++;
      if (alu_i_ready !== 1) begin
        n_fail++;
        $display("FAIL b2b_ready i=%0d ready=%b exp 1",
                 i, alu_i_ready);
      end
    end
    @(posedge clk); #1;
    alu_i_valid = 0;
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    alu_o_ready = 0;
    set_op(K_ADD, 1, 2, 0);
    @(posedge clk); #1;
    alu_i_valid = 0;
    #2;
    rst_n = 0;
    #1;
    n_chk++;
    if (alu_o_valid !== 0 || alu_o_cnt !== 0 ||
        alu_i_ready !== 1 || alu_o_wbck_wdat !== 0) begin
      n_fail++;
      $display("FAIL reset_mid v=%b cnt=%0d r=%b wdat=%h",
               alu_o_valid, alu_o_cnt, alu_i_ready,
               alu_o_wbck_wdat);
    end
    @(negedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_fill();
    test_ecall();
    test_flush();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk); #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover size=%0d exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
